// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding and default address map.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sramState_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  function automatic logic isAccessState(input sramState_e s);
    return (s == LOW) || (s == HIGH);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Modulo-WAIT_CYCLES counter that paces each 16-bit half-access of the SRAM.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5,
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CW-1:0] count;

  // Terminal only fires while counting, so an idle controller never sees a spurious last count.
  assign terminal = enable && (count == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit LDR/STR into two 16-bit asynchronous SRAM accesses, stalling the pipeline via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN,
  output logic               sramOeN
);

  sramState_e state, nextState;
  logic request, inAccess, lastCount;
  logic opRead, opWrite;
  logic [SRAM_AW-2:0] wordAddr;
  logic [31:0] dataLatch;

  assign request  = memRead | memWrite;
  assign inAccess = isAccessState(state);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) waitCounter (
    .clk     (clk),
    .rstN    (rstN),
    .clear   (!inAccess),
    .enable  (inAccess),
    .terminal(lastCount)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (request) nextState = LOW;
      LOW:     if (lastCount) nextState = HIGH;
      HIGH:    if (lastCount) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The request is latched once so the pipeline may drop or change it mid-access.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opRead    <= 1'b0;
      opWrite   <= 1'b0;
      wordAddr  <= '0;
      dataLatch <= '0;
    end else if (state == IDLE && request) begin
      opRead    <= memRead;
      opWrite   <= memWrite & ~memRead;
      wordAddr  <= (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
      dataLatch <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      readData <= '0;
    end else if (inAccess && opRead && lastCount) begin
      if (state == LOW) begin
        readData[15:0] <= sramDqIn;
      end else begin
        readData[31:16] <= sramDqIn;
      end
    end
  end

  // Write enable releases on the last count so address and data are held past the strobe.
  always_comb begin
    ready     = 1'b0;
    sramAddr  = '0;
    sramDqOut = '0;
    sramDqOe  = 1'b0;
    sramWeN   = 1'b1;
    sramOeN   = 1'b1;
    case (state)
      IDLE: ready = !request;
      LOW: begin
        sramAddr = {wordAddr, 1'b0};
        if (opWrite) begin
          sramDqOe  = 1'b1;
          sramDqOut = dataLatch[15:0];
          sramWeN   = lastCount;
        end
        if (opRead) sramOeN = 1'b0;
      end
      HIGH: begin
        sramAddr = {wordAddr, 1'b1};
        if (opWrite) begin
          sramDqOe  = 1'b1;
          sramDqOut = dataLatch[31:16];
          sramWeN   = lastCount;
        end
        if (opRead) sramOeN = 1'b0;
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES 5 and 2), each on its own SRAM model.
module tb_sram_controller;

  localparam int NU = 2;

  logic clk = 1'b0;
  logic rstN;
  logic [NU-1:0]        memRead, memWrite, ready, sramDqOe, sramWeN, sramOeN;
  logic [NU-1:0][31:0]  address, writeData, readData;
  logic [NU-1:0][17:0]  sramAddr;
  logic [NU-1:0][15:0]  sramDqOut, sramDqIn;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : unit
    logic [15:0] mem [0:262143];

    sram_controller #(
      .BASE_ADDR  (32'd1024),
      .WAIT_CYCLES(g == 0 ? 5 : 2),
      .SRAM_AW    (18)
    ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .memRead  (memRead[g]),
      .memWrite (memWrite[g]),
      .address  (address[g]),
      .writeData(writeData[g]),
      .readData (readData[g]),
      .ready    (ready[g]),
      .sramAddr (sramAddr[g]),
      .sramDqOut(sramDqOut[g]),
      .sramDqIn (sramDqIn[g]),
      .sramDqOe (sramDqOe[g]),
      .sramWeN  (sramWeN[g]),
      .sramOeN  (sramOeN[g])
    );

    assign sramDqIn[g] = !sramOeN[g] ? mem[sramAddr[g]] : 16'h0000;

    initial for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

    always @(posedge clk) if (!sramWeN[g]) mem[sramAddr[g]] = sramDqOut[g];
  end

  int vectors = 0;
  int miscompares = 0;
  logic overlapSeen = 1'b0;

  always @(negedge clk) if (|(~sramWeN & ~sramOeN)) overlapSeen = 1'b1;

  // Reference model: word-level memory contents and the last word each unit returned.
  logic [31:0] refMem [NU][64];
  logic [31:0] lastRead [NU];

  int lowCycles, weLow, oeLow, dqOeRead;
  logic [31:0] addrLow, addrHigh, dqLow, dqHigh, doneData;
  bit timedOut;

  typedef struct {
    logic        u;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecTable [10];

  function automatic int waitOf(input logic u);
    return u ? 2 : 5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic u, input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int dropAfter);
    int w;
    bit done;
    w = waitOf(u);
    @(negedge clk);
    memRead[u]   = rd;
    memWrite[u]  = wr;
    address[u]   = addr;
    writeData[u] = wdata;
    #1;
    checkOutput("readyLowOnRequest", 32'(ready[u]), 32'd0);
    lowCycles = 0; weLow = 0; oeLow = 0; dqOeRead = 0;
    addrLow = '0; addrHigh = '0; dqLow = '0; dqHigh = '0; doneData = '0;
    timedOut = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      if (ready[u]) begin
        done = 1'b1;
        doneData = readData[u];
      end else begin
        lowCycles++;
        if (!sramWeN[u]) weLow++;
        if (!sramOeN[u]) oeLow++;
        if (rd && sramDqOe[u]) dqOeRead++;
        if (k == 1) begin
          addrLow = 32'(sramAddr[u]);
          dqLow   = 32'(sramDqOut[u]);
        end
        if (k == w + 1) begin
          addrHigh = 32'(sramAddr[u]);
          dqHigh   = 32'(sramDqOut[u]);
        end
        if (k == dropAfter) begin
          memRead[u]   = 1'b0;
          memWrite[u]  = 1'b0;
          address[u]   = $urandom;
          writeData[u] = $urandom;
        end
      end
    end
    memRead[u]  = 1'b0;
    memWrite[u] = 1'b0;
    if (!done) begin
      timedOut = 1'b1;
      vectors++;
      miscompares++;
      $display("[TB] FAIL accessTimeout: ready still 0 after 64 cycles, required 1 within %0d", 2 * w + 1);
    end
  endtask

  task automatic runChecked(input logic u, input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int dropAfter);
    int w;
    logic [5:0] word;
    logic [31:0] expData;
    w = waitOf(u);
    word = 6'((addr - 32'd1024) >> 2);
    applyStimulus(u, rd, wr, addr, wdata, dropAfter);
    if (timedOut) return;
    expData = rd ? refMem[u][word] : lastRead[u];
    checkOutput("readyLowCycles", 32'(lowCycles), 32'(2 * w));
    checkOutput("weLowCycles", 32'(weLow), (wr && !rd) ? 32'(2 * (w - 1)) : 32'd0);
    checkOutput("oeLowCycles", 32'(oeLow), rd ? 32'(2 * w) : 32'd0);
    checkOutput("dqOeDuringRead", 32'(dqOeRead), 32'd0);
    checkOutput("lowHalfAddr", addrLow, 32'(word) * 2);
    checkOutput("highHalfAddr", addrHigh, 32'(word) * 2 + 1);
    if (wr && !rd) begin
      checkOutput("lowHalfData", dqLow, 32'(wdata[15:0]));
      checkOutput("highHalfData", dqHigh, 32'(wdata[31:16]));
      refMem[u][word] = wdata;
    end
    checkOutput("readData", doneData, expData);
    if (rd) lastRead[u] = expData;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic u, rd, wr;
    int op, w, drop;
    logic [31:0] addr;

    rstN = 1'b0;
    memRead = '0; memWrite = '0; address = '0; writeData = '0;
    for (int i = 0; i < NU; i++) begin
      lastRead[i] = '0;
      for (int j = 0; j < 64; j++) refMem[i][j] = '0;
    end

    vecTable[0] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000};
    vecTable[1] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF};
    vecTable[2] = '{1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF};
    vecTable[3] = '{1'b0, 1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 32'h12345678};
    vecTable[4] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h12345678};
    vecTable[5] = '{1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 32'h12345678};
    vecTable[6] = '{1'b0, 1'b1, 1'b0, 32'd1036, 32'h00000000, 32'hCAFEF00D};
    vecTable[7] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF};
    vecTable[8] = '{1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000};
    vecTable[9] = '{1'b1, 1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      u = 1'(i);
      checkOutput("resetReady", 32'(ready[u]), 32'd1);
      checkOutput("resetWeN", 32'(sramWeN[u]), 32'd1);
      checkOutput("resetOeN", 32'(sramOeN[u]), 32'd1);
      checkOutput("resetDqOe", 32'(sramDqOe[u]), 32'd0);
      checkOutput("resetReadData", readData[u], 32'd0);
    end

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      runChecked(vecTable[i].u, vecTable[i].rd, vecTable[i].wr, vecTable[i].addr, vecTable[i].wdata, 0);
      checkOutput("tableReadData", doneData, vecTable[i].expRead);
    end
    checkOutput("sramWord4", 32'(unit[0].mem[4]), 32'h0000BEEF);
    checkOutput("sramWord5", 32'(unit[0].mem[5]), 32'h0000DEAD);
    checkOutput("dualOpKeepsLow", 32'(unit[0].mem[0]), 32'h00005678);
    checkOutput("dualOpKeepsHigh", 32'(unit[0].mem[1]), 32'h00001234);
    checkOutput("fastUnitWord4", 32'(unit[1].mem[4]), 32'h0000BEEF);

    $display("[TB] reset in the middle of a write");
    @(negedge clk);
    memRead[0] = 1'b0;
    memWrite[0] = 1'b1;
    address[0] = 32'd9216;
    writeData[0] = 32'hA5A55A5A;
    repeat (7) @(negedge clk);
    checkOutput("midHighWeN", 32'(sramWeN[0]), 32'd0);
    checkOutput("midHighAddr", 32'(sramAddr[0]), 32'd4097);
    #2;
    rstN = 1'b0;
    memWrite[0] = 1'b0;
    #1;
    checkOutput("asyncResetReady", 32'(ready[0]), 32'd1);
    checkOutput("asyncResetWeN", 32'(sramWeN[0]), 32'd1);
    checkOutput("asyncResetOeN", 32'(sramOeN[0]), 32'd1);
    checkOutput("asyncResetDqOe", 32'(sramDqOe[0]), 32'd0);
    checkOutput("asyncResetAddr", 32'(sramAddr[0]), 32'd0);
    checkOutput("asyncResetDqOut", 32'(sramDqOut[0]), 32'd0);
    checkOutput("asyncResetReadData", readData[0], 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    lastRead[0] = '0;
    lastRead[1] = '0;
    runChecked(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 0);
    checkOutput("readAfterReset", doneData, 32'hDEADBEEF);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      u = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      rd = (op != 1);
      wr = (op != 0);
      addr = 32'd1024 + 32'd4 * $urandom_range(0, 15);
      w = waitOf(u);
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * w - 1)) : 0;
      runChecked(u, rd, wr, addr, $urandom, drop);
    end

    checkOutput("noWeOeOverlap", 32'(overlapSeen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
